// File: rtl/regfile_ctrl_pkg.sv
// regfile_ctrl_pkg: shared widths, typedefs and grant encoding for the writeback arbiter.
package regfile_ctrl_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam int NUM_REGS = 32;
  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [REG_DATA_W-1:0] reg_data_t;
  typedef logic [NUM_REGS-1:0] busy_vec_t;
  typedef enum logic [1:0] {GNT_NONE, GNT_REQ0, GNT_REQ1} wb_grant_e;
endpackage

// File: rtl/regfile_wb_arbiter_arb2.sv
// wb_arb2: two-input writeback arbiter; fixed req0 priority, or round-robin when WB_ROUND_ROBIN_EN is defined.
module wb_arb2
  import regfile_ctrl_pkg::*;
(
`ifdef WB_ROUND_ROBIN_EN
  input  logic      clk,
`endif
  input  logic      rst,
  input  logic      i_req0,
  input  logic      i_req1,
  output wb_grant_e o_gnt
);
`ifdef WB_ROUND_ROBIN_EN
  // r_prio=1 means req1 is favoured on the next conflict
  logic r_prio;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_prio <= 1'b0;
    else if (o_gnt != GNT_NONE) r_prio <= (o_gnt == GNT_REQ0);
  always_comb
    o_gnt = rst ? GNT_NONE :
            (i_req0 && i_req1) ? (r_prio ? GNT_REQ1 : GNT_REQ0) :
            i_req0 ? GNT_REQ0 : i_req1 ? GNT_REQ1 : GNT_NONE;
`else
  always_comb
    o_gnt = rst ? GNT_NONE : i_req0 ? GNT_REQ0 : i_req1 ? GNT_REQ1 : GNT_NONE;
`endif
endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the register-file write port between two writeback units and tracks busy registers.
// Build option WB_ROUND_ROBIN_EN selects round-robin arbitration instead of fixed req0 priority.
module regfile_wb_arbiter
  import regfile_ctrl_pkg::*;
#(
  parameter int N = REG_ADDR_W,
  parameter int M = REG_DATA_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rsv_valid,
  input  logic [N-1:0]    rsv_addr,
  input  logic            wb0_valid,
  output logic            wb0_ready,
  input  logic [N-1:0]    wb0_addr,
  input  logic [M-1:0]    wb0_data,
  input  logic            wb1_valid,
  output logic            wb1_ready,
  input  logic [N-1:0]    wb1_addr,
  input  logic [M-1:0]    wb1_data,
  output logic            rf_we,
  output logic [N-1:0]    rf_a3,
  output logic [M-1:0]    rf_wd,
  input  logic [N-1:0]    rd_a1,
  input  logic [N-1:0]    rd_a2,
  output logic            stall,
  output logic [2**N-1:0] busy
);
  localparam int R = 2**N;
  wb_grant_e    w_gnt;
  logic         w_acc;
  logic [N-1:0] w_addr;
  logic [M-1:0] w_data;
  logic [R-1:0] w_one, w_set, w_clr;
  logic         r_we;
  logic [N-1:0] r_a3;
  logic [M-1:0] r_wd;
  logic [R-1:0] r_busy;
  wb_arb2 u_arb (
`ifdef WB_ROUND_ROBIN_EN
    .clk(clk),
`endif
    .rst(rst), .i_req0(wb0_valid), .i_req1(wb1_valid), .o_gnt(w_gnt));
  always_comb begin
    wb0_ready = (w_gnt == GNT_REQ0);
    wb1_ready = (w_gnt == GNT_REQ1);
    w_acc = (w_gnt != GNT_NONE);
    w_addr = (w_gnt == GNT_REQ1) ? wb1_addr : wb0_addr;
    w_data = (w_gnt == GNT_REQ1) ? wb1_data : wb0_data;
    w_one = {{(R-1){1'b0}}, 1'b1};
    w_set = (rsv_valid && rsv_addr != '0) ? (w_one << rsv_addr) : '0;
    w_clr = r_we ? (w_one << r_a3) : '0;
  end
  // writes to r0 are accepted but never reach the register file
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_we <= 1'b0;
      r_a3 <= '0;
      r_wd <= '0;
      r_busy <= '0;
    end else begin
      r_we <= w_acc && (w_addr != '0);
      if (w_acc) begin
        r_a3 <= w_addr;
        r_wd <= w_data;
      end
      r_busy <= (r_busy & ~w_clr) | w_set;
    end
  assign rf_we = r_we;
  assign rf_a3 = r_a3;
  assign rf_wd = r_wd;
  assign busy = r_busy;
  assign stall = r_busy[rd_a1] | r_busy[rd_a2];
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed self-checking bench; arbitration expectations follow WB_ROUND_ROBIN_EN.
module tb_regfile_wb_arbiter;
  logic        clk, rst;
  logic        rsv_valid;
  logic [4:0]  rsv_addr;
  logic        wb0_valid, wb0_ready, wb1_valid, wb1_ready;
  logic [4:0]  wb0_addr, wb1_addr;
  logic [31:0] wb0_data, wb1_data;
  logic        rf_we;
  logic [4:0]  rf_a3;
  logic [31:0] rf_wd;
  logic [4:0]  rd_a1, rd_a2;
  logic        stall;
  logic [31:0] busy;
  int n_run, n_fail;
  regfile_wb_arbiter dut (
    .clk(clk), .rst(rst), .rsv_valid(rsv_valid), .rsv_addr(rsv_addr),
    .wb0_valid(wb0_valid), .wb0_ready(wb0_ready), .wb0_addr(wb0_addr), .wb0_data(wb0_data),
    .wb1_valid(wb1_valid), .wb1_ready(wb1_ready), .wb1_addr(wb1_addr), .wb1_data(wb1_data),
    .rf_we(rf_we), .rf_a3(rf_a3), .rf_wd(rf_wd), .rd_a1(rd_a1), .rd_a2(rd_a2),
    .stall(stall), .busy(busy));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask
  initial begin
    n_run = 0;
    n_fail = 0;
    rst = 1'b1;
    rsv_valid = 0; rsv_addr = 0;
    wb0_valid = 1; wb0_addr = 5'd4; wb0_data = 32'h1;
    wb1_valid = 1; wb1_addr = 5'd6; wb1_data = 32'h2;
    rd_a1 = 0; rd_a2 = 0;
    #2;
    chk("rst_ready0", wb0_ready, 0);
    chk("rst_ready1", wb1_ready, 0);
    chk("rst_we", rf_we, 0);
    chk("rst_a3", rf_a3, 0);
    chk("rst_wd", rf_wd, 0);
    chk("rst_busy", busy, 0);
    wb0_valid = 0; wb1_valid = 0;
    tick();
    rst = 1'b0;
    // single write
    wb0_valid = 1; wb0_addr = 5'd5; wb0_data = 32'hDEADBEEF;
    #1;
    chk("single_ready0", wb0_ready, 1);
    chk("single_ready1", wb1_ready, 0);
    tick();
    wb0_valid = 0;
    chk("single_we", rf_we, 1);
    chk("single_a3", rf_a3, 5);
    chk("single_wd", rf_wd, 32'hDEADBEEF);
    tick();
    chk("idle_we", rf_we, 0);
    chk("idle_a3_hold", rf_a3, 5);
    chk("idle_wd_hold", rf_wd, 32'hDEADBEEF);
    // contention
    do_reset();
    wb0_valid = 1; wb0_addr = 5'd1; wb0_data = 32'h11;
    wb1_valid = 1; wb1_addr = 5'd2; wb1_data = 32'h22;
`ifdef WB_ROUND_ROBIN_EN
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("rr_ready0", wb0_ready, (k % 2 == 0));
      chk("rr_ready1", wb1_ready, (k % 2 == 1));
      tick();
      chk("rr_a3", rf_a3, (k % 2 == 0) ? 1 : 2);
    end
    wb0_valid = 0; wb1_valid = 0;
`else
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("fp_ready0", wb0_ready, 1);
      chk("fp_ready1", wb1_ready, 0);
      tick();
      chk("fp_a3", rf_a3, 1);
      chk("fp_wd", rf_wd, 32'h11);
    end
    wb0_valid = 0;
    #1;
    chk("fp_ready1_late", wb1_ready, 1);
    tick();
    wb1_valid = 0;
    chk("fp_a3_late", rf_a3, 2);
    chk("fp_wd_late", rf_wd, 32'h22);
`endif
    tick();
    // scoreboard and stall release
    rsv_valid = 1; rsv_addr = 5'd7;
    tick();
    rsv_valid = 0;
    rd_a1 = 5'd7; rd_a2 = 5'd0;
    #1;
    chk("sb_busy7", busy[7], 1);
    chk("sb_stall", stall, 1);
    wb1_valid = 1; wb1_addr = 5'd7; wb1_data = 32'h77;
    #1;
    chk("sb_ready1", wb1_ready, 1);
    tick();
    wb1_valid = 0;
    chk("sb_we", rf_we, 1);
    chk("sb_a3", rf_a3, 7);
    chk("sb_stall_commit", stall, 1);
    tick();
    chk("sb_stall_drop", stall, 0);
    chk("sb_busy7_clr", busy[7], 0);
    // reserve and commit r3 on the same edge
    rsv_valid = 1; rsv_addr = 5'd3;
    tick();
    rsv_valid = 0;
    wb0_valid = 1; wb0_addr = 5'd3; wb0_data = 32'h33;
    tick();
    wb0_valid = 0;
    rsv_valid = 1; rsv_addr = 5'd3;
    chk("col_we", rf_we, 1);
    chk("col_a3", rf_a3, 3);
    tick();
    rsv_valid = 0;
    rd_a1 = 5'd0; rd_a2 = 5'd3;
    #1;
    chk("col_busy3", busy[3], 1);
    chk("col_stall", stall, 1);
    // register 0
    rsv_valid = 1; rsv_addr = 5'd0;
    tick();
    rsv_valid = 0;
    chk("r0_busy0", busy[0], 0);
    wb0_valid = 1; wb0_addr = 5'd0; wb0_data = 32'hAA;
    #1;
    chk("r0_ready0", wb0_ready, 1);
    tick();
    wb0_valid = 0;
    chk("r0_we", rf_we, 0);
    chk("r0_busy0_after", busy[0], 0);
    // reset with a write in flight
    wb0_valid = 1; wb0_addr = 5'd9; wb0_data = 32'h99;
    tick();
    wb0_valid = 0;
    chk("mid_we_pre", rf_we, 1);
    rst = 1'b1;
    #1;
    chk("mid_we", rf_we, 0);
    chk("mid_busy", busy, 0);
    chk("mid_a3", rf_a3, 0);
    chk("mid_stall", stall, 0);
    tick();
    rst = 1'b0;
    tick();
    chk("post_we", rf_we, 0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
